rf_writeback: RTL

Write-side master for the 32x32 register file. Merges single-cycle ALU results and variable-latency load returns onto the file's single write port (we / rd_addr / rd_data), with a small load-return FIFO. Performs load byte/half extraction and sign/zero extension. Keeps a pending-load scoreboard that the issue stage uses for RAW/WAW hazard detection. Sits between execute/LSU and the register file.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 47 ++++
 rtl/rf_writeback.sv | 89 ++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, load funct3 encodings and load-data extension.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int AW = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_funct3_e;

    // Unrecognised funct3 codes fall back to a full-word load.
    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] word);
        logic [7:0] b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        return funct3 == LB  ? {{(XLEN-8){b[7]}}, b} :
               funct3 == LH  ? {{(XLEN-16){h[15]}}, h} :
               funct3 == LBU ? {{(XLEN-8){1'b0}}, b} :
               funct3 == LHU ? {{(XLEN-16){1'b0}}, h} : word;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module wb_fifo #(
    parameter int DW = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic do_push, do_pop;

    always_comb begin
        full = count == CW'(DEPTH);
        empty = count == '0;
        do_push = push & ~full;
        do_pop = pop & ~empty;
        rdata = mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + PW'(do_push);
            rptr <= rptr + PW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates ALU results and queued load returns onto the register-file write port
// and tracks destinations of in-flight loads for hazard detection.
module rf_writeback import rv_pkg::*; #(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int AW = rv_pkg::AW,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic            ld_issue_valid,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_data
);
    localparam int EW = AW + XLEN;

    logic [EW-1:0] head;
    logic [$clog2(QDEPTH):0] count;
    logic full, empty, push, pop, sel_alu;
    logic [AW-1:0] head_rd, wr_rd;
    logic [XLEN-1:0] head_data, wr_data;
    logic [2**AW-1:0] pending, pending_nxt;

    wb_fifo #(.DW(EW), .DEPTH(QDEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .wdata({ld_rd, load_extend(ld_funct3, ld_off, ld_data)}),
        .pop(pop),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // The ALU has priority unless the load queue is full, which forces a drain.
    always_comb begin
        ld_ready = count < ($clog2(QDEPTH) + 1)'(QDEPTH);
        push = ld_valid & ld_ready;
        sel_alu = alu_valid & ld_ready;
        alu_stall = alu_valid & full;
        pop = ~empty & ~sel_alu;
        head_rd = head[EW-1 -: AW];
        head_data = head[XLEN-1:0];
        wr_rd = sel_alu ? alu_rd : head_rd;
        wr_data = sel_alu ? alu_data : head_data;
        hazard_rs1 = pending[rs1];
        hazard_rs2 = pending[rs2];
    end

    // A new issue to the same rd as a retiring load keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head_rd] = 1'b0;
        if (ld_issue_valid) pending_nxt[ld_issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            pending <= '0;
        end else begin
            rf_we <= (sel_alu | pop) & (wr_rd != '0);
            if (sel_alu | pop) begin
                rf_rd_addr <= wr_rd;
                rf_rd_data <= wr_data;
            end
            pending <= pending_nxt;
        end
    end
endmodule
